// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and constants for the alarm sequencer
package alarm_pkg;

  localparam int TW            = 6;
  localparam int HOURS_PER_DAY = 24;
  localparam int MIN_PER_HOUR  = 60;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

endpackage

// File: rtl/alarm_ctrl_if.sv
// rtl/alarm_ctrl_if.sv - time inputs, user controls and status outputs of alarm_ctrl
interface alarm_ctrl_if;
  import alarm_pkg::*;

  logic          tick;
  logic [TW-1:0] hour;
  logic [TW-1:0] minute;
  logic [TW-1:0] second;
  logic          arm;
  logic          load;
  logic [TW-1:0] al_hour_in;
  logic [TW-1:0] al_min_in;
  logic          snooze;
  logic          stop;
  logic          ring;
  logic [1:0]    state;
  logic [1:0]    snooze_cnt;
  logic [TW-1:0] al_hour;
  logic [TW-1:0] al_min;
  logic          load_err;

  // driver side: time source and user controls
  modport master (
    output tick, hour, minute, second, arm, load, al_hour_in, al_min_in, snooze, stop,
    input  ring, state, snooze_cnt, al_hour, al_min, load_err
  );

  // alarm sequencer side
  modport slave (
    input  tick, hour, minute, second, arm, load, al_hour_in, al_min_in, snooze, stop,
    output ring, state, snooze_cnt, al_hour, al_min, load_err
  );

endinterface

// File: rtl/time_add_min.sv
// rtl/time_add_min.sv - hour:minute plus a constant number of minutes, wrapping at midnight
module time_add_min
  import alarm_pkg::*;
#(
  parameter int ADD_MIN = 5
) (
  input  logic [TW-1:0] i_hour,
  input  logic [TW-1:0] i_min,
  output logic [TW-1:0] o_hour,
  output logic [TW-1:0] o_min
);

  logic [6:0] w_sum;

  // 7-bit minute sum cannot overflow for 59 + 59; carry into the hour on >= 60
  always_comb begin
    w_sum  = {1'b0, i_min} + 7'(ADD_MIN);
    o_min  = w_sum[TW-1:0];
    o_hour = i_hour;
    if (w_sum >= 7'(MIN_PER_HOUR)) begin
      o_min  = TW'(w_sum - 7'(MIN_PER_HOUR));
      o_hour = (i_hour == TW'(HOURS_PER_DAY - 1)) ? '0 : i_hour + TW'(1);
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm sequencer (armed/ringing/snooze); ALARM_BEEP_EN makes ring beep at 1 Hz
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int MAX_SNOOZE     = 3
) (
  input logic         clk,
  input logic         rst,
  alarm_ctrl_if.slave bus
);

  state_t        r_state;
  logic          r_ring;
  logic [1:0]    r_snooze_cnt;
  logic [TW-1:0] r_al_h;
  logic [TW-1:0] r_al_m;
  logic [TW-1:0] r_tgt_h;
  logic [TW-1:0] r_tgt_m;
  logic [7:0]    r_timer;
  logic          r_load_err;

  state_t        w_nxt_state;
  logic          w_nxt_ring;
  logic [1:0]    w_nxt_cnt;
  logic [TW-1:0] w_nxt_tgt_h;
  logic [TW-1:0] w_nxt_tgt_m;
  logic [7:0]    w_nxt_timer;
  logic [TW-1:0] w_snz_h;
  logic [TW-1:0] w_snz_m;
  logic          w_load_ok;
  logic          w_match;
  logic          w_timeout;
  logic          w_snooze_ok;
  logic          w_end_event;

  time_add_min #(.ADD_MIN(SNOOZE_MIN)) u_snooze_add (
    .i_hour (bus.hour),
    .i_min  (bus.minute),
    .o_hour (w_snz_h),
    .o_min  (w_snz_m)
  );

  assign w_load_ok   = bus.load && (bus.al_hour_in < TW'(HOURS_PER_DAY))
                                && (bus.al_min_in  < TW'(MIN_PER_HOUR));
  // only sampled on tick so a given minute can fire once
  assign w_match     = bus.tick && (bus.hour == r_tgt_h) && (bus.minute == r_tgt_m)
                                && (bus.second == '0);
  assign w_timeout   = bus.tick && (r_timer == 8'(RING_TIMEOUT_S - 1));
  assign w_snooze_ok = bus.snooze && (r_snooze_cnt < 2'(MAX_SNOOZE));
  // stop (anywhere past ARMED) and ring timeout share the same return-to-ARMED effects
  assign w_end_event = (bus.stop && (r_state != ARMED)) || ((r_state == RINGING) && w_timeout);

  // next-state: arm=0 > stop > timeout > snooze > match
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ring  = r_ring;
    w_nxt_cnt   = r_snooze_cnt;
    w_nxt_timer = r_timer;
    w_nxt_tgt_h = r_tgt_h;
    w_nxt_tgt_m = r_tgt_m;
    if ((r_state == ARMED) && w_load_ok) begin
      w_nxt_tgt_h = bus.al_hour_in;
      w_nxt_tgt_m = bus.al_min_in;
    end
    if (r_state == IDLE) begin
      w_nxt_ring  = 1'b0;
      w_nxt_cnt   = '0;
      w_nxt_timer = '0;
      if (bus.arm) begin
        w_nxt_state = ARMED;
        w_nxt_tgt_h = r_al_h;
        w_nxt_tgt_m = r_al_m;
      end
    end else if (!bus.arm) begin
      w_nxt_state = IDLE;
      w_nxt_ring  = 1'b0;
      w_nxt_cnt   = '0;
      w_nxt_timer = '0;
    end else if (w_end_event) begin
      w_nxt_state = ARMED;
      w_nxt_ring  = 1'b0;
      w_nxt_cnt   = '0;
      w_nxt_timer = '0;
      w_nxt_tgt_h = r_al_h;
      w_nxt_tgt_m = r_al_m;
    end else begin
      case (r_state)
        ARMED, SNOOZE: begin
          if (w_match) begin
            w_nxt_state = RINGING;
            w_nxt_ring  = 1'b1;
            w_nxt_timer = '0;
          end
        end
        RINGING: begin
          if (w_snooze_ok) begin
            w_nxt_state = SNOOZE;
            w_nxt_ring  = 1'b0;
            w_nxt_cnt   = r_snooze_cnt + 2'd1;
            w_nxt_tgt_h = w_snz_h;
            w_nxt_tgt_m = w_snz_m;
          end else if (bus.tick) begin
            w_nxt_timer = r_timer + 8'd1;
`ifdef ALARM_BEEP_EN
            w_nxt_ring  = ~r_ring;
`else
            w_nxt_ring  = 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // state and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ring       <= 1'b0;
      r_snooze_cnt <= '0;
      r_timer      <= '0;
      r_tgt_h      <= '0;
      r_tgt_m      <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_ring       <= w_nxt_ring;
      r_snooze_cnt <= w_nxt_cnt;
      r_timer      <= w_nxt_timer;
      r_tgt_h      <= w_nxt_tgt_h;
      r_tgt_m      <= w_nxt_tgt_m;
    end
  end

  // alarm setpoint storage and load rejection pulse, independent of state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_al_h     <= '0;
      r_al_m     <= '0;
      r_load_err <= 1'b0;
    end else begin
      if (w_load_ok) begin
        r_al_h <= bus.al_hour_in;
        r_al_m <= bus.al_min_in;
      end
      r_load_err <= bus.load && !w_load_ok;
    end
  end

  assign bus.ring       = r_ring;
  assign bus.state      = r_state;
  assign bus.snooze_cnt = r_snooze_cnt;
  assign bus.al_hour    = r_al_h;
  assign bus.al_min     = r_al_m;
  assign bus.load_err   = r_load_err;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - scoreboard bench for alarm_ctrl against a minutes-of-day reference model
module tb_alarm_ctrl;

  localparam int SNOOZE_MIN     = 5;
  localparam int RING_TIMEOUT_S = 60;
  localparam int MAX_SNOOZE     = 3;

  typedef struct {
    bit ring;
    int state;
    int cnt;
    int ah;
    int am;
    bit err;
  } exp_t;

  logic clk;
  logic rst;
  alarm_ctrl_if bus();

  alarm_ctrl #(
    .SNOOZE_MIN     (SNOOZE_MIN),
    .RING_TIMEOUT_S (RING_TIMEOUT_S),
    .MAX_SNOOZE     (MAX_SNOOZE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   rst_seen = 0;

  // stimulus state
  int t_h, t_m, t_s;
  bit v_arm, v_rst;
  int v_lh, v_lm;

  // reference model: mode 0..3, times as minutes of the day
  int m_mode, m_cnt, m_al, m_tgt, m_ticks;
  bit m_err;

  function automatic void model_reset();
    m_mode = 0; m_cnt = 0; m_al = 0; m_tgt = 0; m_ticks = 0; m_err = 0;
  endfunction

  function automatic bit model_ring();
`ifdef ALARM_BEEP_EN
    return (m_mode == 2) && (m_ticks % 2 == 0);
`else
    return (m_mode == 2);
`endif
  endfunction

  function automatic void model_step(bit r, bit tk, bit arm, bit ld, int lh, int lm, bit snz, bit stp);
    bit ok, match;
    int now, old_al;
    if (r) begin
      model_reset();
      return;
    end
    now    = t_h * 60 + t_m;
    ok     = ld && lh < 24 && lm < 60;
    match  = tk && now == m_tgt && t_s == 0;
    old_al = m_al;
    m_err  = ld && !ok;
    if (ok) m_al = lh * 60 + lm;
    if (m_mode == 0) begin
      if (arm) begin m_mode = 1; m_tgt = old_al; end
    end else if (!arm) begin
      m_mode = 0; m_cnt = 0; m_ticks = 0;
    end else if ((stp && m_mode != 1) || (m_mode == 2 && tk && m_ticks + 1 >= RING_TIMEOUT_S)) begin
      m_mode = 1; m_cnt = 0; m_ticks = 0; m_tgt = old_al;
    end else if (m_mode == 1) begin
      if (ok) m_tgt = m_al;
      if (match) begin m_mode = 2; m_ticks = 0; end
    end else if (m_mode == 2) begin
      if (snz && m_cnt < MAX_SNOOZE) begin
        m_mode = 3; m_cnt++; m_tgt = (now + SNOOZE_MIN) % 1440;
      end else if (tk) begin
        m_ticks++;
      end
    end else begin
      if (match) begin m_mode = 2; m_ticks = 0; end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.ring = model_ring(); e.state = m_mode; e.cnt = m_cnt;
    e.ah = m_al / 60; e.am = m_al % 60; e.err = m_err;
    return e;
  endfunction

  task automatic check(input exp_t e, input string name);
    n_vec++;
    if (bus.ring !== e.ring || int'(bus.state) != e.state || int'(bus.snooze_cnt) != e.cnt ||
        int'(bus.al_hour) != e.ah || int'(bus.al_min) != e.am || bus.load_err !== e.err) begin
      n_miss++;
      $display("FAIL %s @%0t: got ring=%0d state=%0d cnt=%0d al=%0d:%0d err=%0d, want ring=%0d state=%0d cnt=%0d al=%0d:%0d err=%0d",
               name, $time, bus.ring, bus.state, bus.snooze_cnt, bus.al_hour, bus.al_min, bus.load_err,
               e.ring, e.state, e.cnt, e.ah, e.am, e.err);
    end
  endtask

  // monitor: async reset check on rst rise, otherwise one expected vector per clock
  always @(negedge clk or posedge rst) begin
    if (rst && !rst_seen) begin
      exp_t z;
      z.ring = 0; z.state = 0; z.cnt = 0; z.ah = 0; z.am = 0; z.err = 0;
      rst_seen = 1;
      #1;
      check(z, "async_reset");
    end else begin
      rst_seen = rst;
      if (exp_q.size() > 0) check(exp_q.pop_front(), "cycle");
    end
  end

  task automatic advance_time();
    t_s++;
    if (t_s == 60) begin
      t_s = 0; t_m++;
      if (t_m == 60) begin t_m = 0; t_h = (t_h + 1) % 24; end
    end
  endtask

  task automatic cyc(input bit tk = 0, input bit ld = 0, input bit snz = 0, input bit stp = 0);
    @(negedge clk);
    if (tk) advance_time();
    bus.tick = tk; bus.hour = 6'(t_h); bus.minute = 6'(t_m); bus.second = 6'(t_s);
    bus.arm = v_arm; bus.load = ld; bus.al_hour_in = 6'(v_lh); bus.al_min_in = 6'(v_lm);
    bus.snooze = snz; bus.stop = stp; rst = v_rst;
    #1;
    model_step(v_rst, tk, v_arm, ld, v_lh, v_lm, snz, stp);
    exp_q.push_back(model_out());
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1);
      cyc(0);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    t_h = h; t_m = m; t_s = s;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #2;
    model_reset();
    v_rst = 1; cyc();
    v_rst = 0; cyc();
  endtask

  initial begin
    rst = 1'b0; v_rst = 1; v_arm = 0; v_lh = 0; v_lm = 0;
    set_time(7, 0, 0);
    bus.tick = 0; bus.hour = 0; bus.minute = 0; bus.second = 0; bus.arm = 0; bus.load = 0;
    bus.al_hour_in = 0; bus.al_min_in = 0; bus.snooze = 0; bus.stop = 0;
    model_reset();
    #2 rst = 1'b1;
    cyc(); cyc();
    v_rst = 0;
    cyc();

    // ring at 07:30:00, no re-trigger at 07:30:01
    v_lh = 7; v_lm = 30; cyc(0, 1);
    v_arm = 1; cyc(); cyc();
    set_time(7, 29, 58); tick_n(2); tick_n(1);
    // three snoozes, fourth ignored, then timeout
    cyc(0, 0, 1); cyc();
    set_time(7, 34, 59); tick_n(1);
    cyc(0, 0, 1); set_time(7, 39, 59); tick_n(1);
    cyc(0, 0, 1); set_time(7, 44, 59); tick_n(1);
    cyc(0, 0, 1); cyc();
    tick_n(RING_TIMEOUT_S + 1);

    // snooze across midnight
    v_lh = 23; v_lm = 58; cyc(0, 1); cyc();
    set_time(23, 57, 59); tick_n(1);
    cyc(0, 0, 1); cyc();
    set_time(0, 2, 59); tick_n(1);
    cyc(0, 0, 0, 1); cyc();

    // rejected load, then stop+snooze together
    v_lh = 24; v_lm = 10; cyc(0, 1); cyc();
    v_lh = 12; v_lm = 60; cyc(0, 1); cyc();
    set_time(23, 57, 59); tick_n(1);
    cyc(0, 0, 1, 1); cyc();

    // reset mid-ring, then disarm during snooze
    set_time(23, 57, 59); tick_n(1); cyc();
    async_reset();
    v_lh = 6; v_lm = 15; cyc(0, 1); cyc();
    set_time(6, 14, 59); tick_n(1);
    cyc(0, 0, 1); cyc();
    v_arm = 0; cyc(); cyc();
    v_arm = 1; cyc();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit tk, ld, snz, stp;
      tk  = 1'($urandom_range(0, 1));
      ld  = $urandom_range(0, 99) < 3;
      snz = $urandom_range(0, 99) < 4;
      stp = $urandom_range(0, 99) < 2;
      if (ld) begin v_lh = $urandom_range(0, 25); v_lm = $urandom_range(0, 63); end
      if ($urandom_range(0, 299) == 0) v_arm = !v_arm;
      if ($urandom_range(0, 149) == 0) begin
        int tm;
        tm = (m_tgt + 1439) % 1440;
        set_time(tm / 60, tm % 60, 59);
      end
      cyc(tk, ld, snz, stp);
    end

    cyc();
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
